muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit in the execute stage, next to the ALU; consumes register-file read data (rs, rt).

---
 rtl/muldiv_unit_pkg.sv | 20 ++
 rtl/muldiv_step.sv | 31 +++
 rtl/muldiv_unit.sv | 116 +++++++++++
 tb/tb_muldiv_unit.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings and small op-decode helpers.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring
// trial-subtract for divide, both on a shared 2*WIDTH accumulator.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               i_div,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    output logic [2*WIDTH-1:0] o_acc
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // Multiply keeps {partial, multiplier} and shifts right; divide keeps
    // {remainder, dividend/quotient} and shifts left.
    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
        w_shift = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_diff  = w_shift - {1'b0, i_operand};
        if (i_div) begin
            if (w_diff[WIDTH])
                o_acc = {w_shift[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            else
                o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
        end else begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; one launch cycle,
// WIDTH iteration cycles and one sign-fix cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

    state_e             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic               r_div, r_neg_res, r_neg_rem, r_done;
    logic [WIDTH-1:0]   r_operand, r_hi, r_lo;
    logic [2*WIDTH-1:0] r_acc, w_step, w_prod;
    logic               w_sgn, w_a_neg, w_b_neg, w_launch;
    logic [WIDTH-1:0]   w_a_abs, w_b_abs;
    md_op_e             w_op;

    assign w_op     = md_op_e'(op);
    assign w_sgn    = op_is_signed(w_op);
    assign w_a_neg  = w_sgn & rs_data[WIDTH-1];
    assign w_b_neg  = w_sgn & rt_data[WIDTH-1];
    assign w_a_abs  = w_a_neg ? -rs_data : rs_data;
    assign w_b_abs  = w_b_neg ? -rt_data : rt_data;
    assign w_launch = (r_state == S_IDLE) && start;
    assign w_prod   = r_neg_res ? -r_acc : r_acc;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_div     (r_div),
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .o_acc     (w_step)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_next = S_CALC;
            S_CALC:  if (r_cnt == CW'(WIDTH-1)) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_div     <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_done    <= 1'b0;
            r_operand <= '0;
            r_acc     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_cnt     <= '0;
                        r_div     <= op_is_div(w_op);
                        r_neg_rem <= w_a_neg;
                        // Divide by zero keeps the all-ones quotient unnegated.
                        r_neg_res <= (w_a_neg ^ w_b_neg) & ~(op_is_div(w_op) & (rt_data == '0));
                        r_operand <= op_is_div(w_op) ? w_b_abs : w_a_abs;
                        r_acc     <= {{WIDTH{1'b0}}, op_is_div(w_op) ? w_a_abs : w_b_abs};
                    end else begin
                        if (mthi) r_hi <= rs_data;
                        if (mtlo) r_lo <= rs_data;
                    end
                end
                S_CALC: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    if (r_div) begin
                        r_lo <= r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                        r_hi <= r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO queued at launch,
// compared on each done pulse; plus latency, hold, MTHI/MTLO and reset checks.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0, reset = 1'b1, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] rs_data = '0, rt_data = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int checks = 0, errors = 0, done_cnt = 0;
    logic [2*W-1:0] sb_q[$];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Reference {hi,lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: r = sa * sb;
            2'd1: r = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 0)     r = {a, 32'hFFFFFFFF};
                else if (o == 2) r = {32'(sa % sb), 32'(sa / sb)};
                else            r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            if (sb_q.size() == 0) chk("spurious_done", {63'b0, done}, 64'd0);
            else                  chk("result", {hi, lo}, sb_q.pop_front());
        end
    end

    // Launch one op; optionally drive mthi/mtlo alongside start, and a
    // colliding start+mthi at cycle `coll` of the op.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input bit mt, input int coll);
        int n, d0;
        logic [63:0] old;
        @(negedge clk);
        op = o; rs_data = a; rt_data = b; start = 1'b1; mthi = mt; mtlo = mt;
        old = {hi, lo};
        sb_q.push_back(model(o, a, b));
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        rs_data = $urandom; rt_data = $urandom;
        n = 1;
        chk({tag, "_busy"}, {63'b0, busy}, 64'd1);
        while (busy && n < 100) begin
            if (n == coll) begin
                start = 1'b1; mthi = 1'b1; op = 2'd3; rs_data = 32'd5; rt_data = 32'd0;
            end
            @(posedge clk); #1;
            n++;
            start = 1'b0; mthi = 1'b0;
            if (n == 20) chk({tag, "_hold"}, {hi, lo}, old);
        end
        chk({tag, "_latency"}, n, 34);
        chk({tag, "_done_at_fall"}, {63'b0, done}, 64'd1);
        repeat (2) @(negedge clk);
        chk({tag, "_done_once"}, done_cnt - d0, 1);
    endtask

    initial begin
        #12;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", {63'b0, busy}, 0);
        chk("rst_done", {63'b0, done}, 0);
        @(negedge clk) reset = 1'b0;

        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu", 1'b0, -1);
        chk("multu_const", {hi, lo}, 64'hFFFFFFFE_00000001);
        run_op(2'd0, -32'sd3, 32'd7, "mult", 1'b0, -1);
        chk("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_op(2'd2, -32'sd7, 32'd2, "div", 1'b0, -1);
        chk("div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(2'd3, 32'd100, 32'd7, "divu", 1'b1, -1);
        chk("divu_const", {hi, lo}, {32'd2, 32'd14});
        run_op(2'd3, 32'd5, 32'd0, "divu0", 1'b0, -1);
        chk("divu0_const", {hi, lo}, {32'd5, 32'hFFFFFFFF});
        run_op(2'd2, -32'sd9, 32'd0, "div0", 1'b0, -1);
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, "ovf", 1'b0, -1);
        chk("ovf_const", {hi, lo}, {32'd0, 32'h80000000});
        run_op(2'd0, 32'h00012345, 32'hFFFF0001, "coll", 1'b0, 10);

        @(negedge clk); rs_data = 32'hAB; mtlo = 1'b1;
        @(posedge clk); #1 mtlo = 1'b0;
        chk("mtlo", lo, 32'hAB);
        @(negedge clk); rs_data = 32'hCD; mthi = 1'b1;
        @(posedge clk); #1 mthi = 1'b0;
        chk("mthi", hi, 32'hCD);
        chk("mthi_lo_kept", lo, 32'hAB);
        @(negedge clk); rs_data = 32'h55; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1 mthi = 1'b0; mtlo = 1'b0;
        chk("mt_both", {hi, lo}, {32'h55, 32'h55});

        @(negedge clk); op = 2'd2; rs_data = -32'sd100; rt_data = 32'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (14) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_busy", {63'b0, busy}, 0);
        @(negedge clk) reset = 1'b0;

        run_op(2'd3, 32'd9, 32'd3, "divu93", 1'b0, -1);
        chk("divu93_const", {hi, lo}, {32'd0, 32'd3});

        for (int i = 0; i < 6; i++)
            run_op(2'($urandom_range(0, 3)), $urandom, (i == 2) ? 32'd0 : $urandom, "rand", 1'b0, -1);

        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
